// File: rtl/guess_recorder.sv
// Guess entry and history recorder: assembles a multi-digit guess from button pulses
// and commits complete guesses into an eight-slot history that feeds the LED display.
// Latency: entry updates one edge after a pulse; a commit lands one edge after the COMMIT cycle.
module guess_recorder #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 3,
    parameter int MAX_GUESSES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        new_game,
    input  logic [DIGIT_W-1:0]          digit_in,
    input  logic                        btn_enter,
    input  logic                        btn_back,
    input  logic                        btn_submit,
    output logic [DIGITS*DIGIT_W-1:0]   cur_guess,
    output logic [2:0]                  cur_len,
    output logic [DIGITS*DIGIT_W-1:0]   g1,
    output logic [DIGITS*DIGIT_W-1:0]   g2,
    output logic [DIGITS*DIGIT_W-1:0]   g3,
    output logic [DIGITS*DIGIT_W-1:0]   g4,
    output logic [DIGITS*DIGIT_W-1:0]   g5,
    output logic [DIGITS*DIGIT_W-1:0]   g6,
    output logic [DIGITS*DIGIT_W-1:0]   g7,
    output logic [DIGITS*DIGIT_W-1:0]   g8,
    output logic [3:0]                  guess_count,
    output logic                        guess_valid,
    output logic                        full
);

    localparam int             GW      = DIGITS * DIGIT_W;
    localparam logic [2:0]     LEN_MAX = 3'(DIGITS);
    localparam logic [3:0]     CNT_MAX = 4'(MAX_GUESSES);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        READY  = 2'd1,
        COMMIT = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   cur_guess_q, cur_guess_d;
    logic [2:0]      cur_len_q, cur_len_d;
    logic [GW-1:0]   slot_q [MAX_GUESSES];
    logic [GW-1:0]   slot_d [MAX_GUESSES];
    logic [3:0]      guess_count_q, guess_count_d;
    logic            guess_valid_q, guess_valid_d;
    logic            full_q, full_d;

    // Next-state logic; buttons resolve by priority new_game > submit > back > enter,
    // and the state then decides whether the winning button has any effect.
    always_comb begin
        state_d       = state_q;
        cur_guess_d   = cur_guess_q;
        cur_len_d     = cur_len_q;
        slot_d        = slot_q;
        guess_count_d = guess_count_q;
        guess_valid_d = 1'b0;

        if (new_game) begin
            // Also discards a commit in flight: the slot write below never happens.
            for (int i = 0; i < MAX_GUESSES; i++) begin
                slot_d[i] = '0;
            end
            guess_count_d = '0;
            cur_guess_d   = '0;
            cur_len_d     = '0;
            state_d       = ENTRY;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (btn_submit) begin
                        // incomplete entry: submit swallowed, lower buttons masked
                    end else if (btn_back) begin
                        if (cur_len_q != 3'd0) begin
                            cur_guess_d[(DIGITS - int'(cur_len_q)) * DIGIT_W +: DIGIT_W] = '0;
                            cur_len_d = cur_len_q - 3'd1;
                        end
                    end else if (btn_enter) begin
                        if (cur_len_q < LEN_MAX) begin
                            cur_guess_d[(DIGITS - 1 - int'(cur_len_q)) * DIGIT_W +: DIGIT_W] = digit_in;
                            cur_len_d = cur_len_q + 3'd1;
                            if (cur_len_q + 3'd1 == LEN_MAX) begin
                                state_d = READY;
                            end
                        end
                    end
                end
                READY: begin
                    if (btn_submit) begin
                        state_d = COMMIT;
                    end else if (btn_back) begin
                        cur_guess_d[DIGIT_W-1:0] = '0;
                        cur_len_d = LEN_MAX - 3'd1;
                        state_d   = ENTRY;
                    end
                end
                COMMIT: begin
                    if (guess_count_q < CNT_MAX) begin
                        slot_d[guess_count_q[2:0]] = cur_guess_q;
                        guess_count_d = guess_count_q + 4'd1;
                        guess_valid_d = 1'b1;
                    end
                    cur_guess_d = '0;
                    cur_len_d   = '0;
                    state_d     = (guess_count_d == CNT_MAX) ? FULL : ENTRY;
                end
                FULL: begin
                    // parked until new_game or rst
                end
                default: state_d = ENTRY;
            endcase
        end

        full_d = (state_d == FULL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ENTRY;
            cur_guess_q   <= '0;
            cur_len_q     <= '0;
            guess_count_q <= '0;
            guess_valid_q <= 1'b0;
            full_q        <= 1'b0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cur_guess_q   <= cur_guess_d;
            cur_len_q     <= cur_len_d;
            guess_count_q <= guess_count_d;
            guess_valid_q <= guess_valid_d;
            full_q        <= full_d;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign cur_guess   = cur_guess_q;
    assign cur_len     = cur_len_q;
    assign guess_count = guess_count_q;
    assign guess_valid = guess_valid_q;
    assign full        = full_q;
    assign g1 = slot_q[0];
    assign g2 = slot_q[1];
    assign g3 = slot_q[2];
    assign g4 = slot_q[3];
    assign g5 = slot_q[4];
    assign g6 = slot_q[5];
    assign g7 = slot_q[6];
    assign g8 = slot_q[7];

endmodule

// File: tb/tb_guess_recorder.sv
// Bench for guess_recorder: scenario tasks drive button pulses; committed guesses are
// queued as expected and matched by a monitor whenever guess_valid fires.
module tb_guess_recorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game, btn_enter, btn_back, btn_submit;
    logic [2:0]  digit_in;
    logic [11:0] cur_guess;
    logic [2:0]  cur_len;
    logic [11:0] g1, g2, g3, g4, g5, g6, g7, g8;
    logic [3:0]  guess_count;
    logic        guess_valid, full;

    logic [11:0] gs [8];
    assign gs[0] = g1; assign gs[1] = g2; assign gs[2] = g3; assign gs[3] = g4;
    assign gs[4] = g5; assign gs[5] = g6; assign gs[6] = g7; assign gs[7] = g8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] val;
        int          slot;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    guess_recorder dut (
        .clk(clk), .rst(rst), .new_game(new_game), .digit_in(digit_in),
        .btn_enter(btn_enter), .btn_back(btn_back), .btn_submit(btn_submit),
        .cur_guess(cur_guess), .cur_len(cur_len),
        .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5), .g6(g6), .g7(g7), .g8(g8),
        .guess_count(guess_count), .guess_valid(guess_valid), .full(full)
    );

    // Scoreboard: every guess_valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst === 1'b0 && guess_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: guess_valid with count=%0d, required no commit", guess_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (gs[e.slot] !== e.val || guess_count !== 4'(e.slot + 1)) begin
                    bad++;
                    $display("FAIL sb_commit: slot%0d=%o count=%0d, required %o count=%0d",
                             e.slot + 1, gs[e.slot], guess_count, e.val, e.slot + 1);
                end
            end
        end
    end

    // One clock of stimulus: inputs set at negedge, released #1 after the posedge.
    task automatic pulse(input logic en, input logic bk, input logic sb_, input logic ng,
                         input logic [2:0] d);
        @(negedge clk);
        btn_enter = en; btn_back = bk; btn_submit = sb_; new_game = ng; digit_in = d;
        @(posedge clk);
        #1;
        btn_enter = 0; btn_back = 0; btn_submit = 0; new_game = 0; digit_in = 0;
    endtask

    task automatic enter_digits(input logic [11:0] v);
        for (int i = 3; i >= 0; i--) begin
            pulse(1, 0, 0, 0, v[i*3 +: 3]);
        end
    endtask

    // Submit a complete entry and let the COMMIT cycle pass; guess_valid is then high.
    task automatic commit_guess(input logic [11:0] v, input int slot);
        exp_t e;
        enter_digits(v);
        e.val = v; e.slot = slot;
        sb.push_back(e);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (guess_valid !== 1'b1 || cur_len !== 3'd0 || cur_guess !== 12'd0) begin
            bad++;
            $display("FAIL commit_pulse: valid=%b len=%0d cur=%o, required 1 0 0",
                     guess_valid, cur_len, cur_guess);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic any;
        any = 1'b0;
        for (int i = 0; i < 8; i++) if (gs[i] !== 12'd0) any = 1'b1;
        total++;
        if (any || cur_guess !== 0 || cur_len !== 0 || guess_count !== 0 ||
            guess_valid !== 0 || full !== 0) begin
            bad++;
            $display("FAIL %s: cur=%o len=%0d cnt=%0d valid=%b full=%b slots_nonzero=%b, required all 0",
                     name, cur_guess, cur_len, guess_count, guess_valid, full, any);
        end
    endtask

    task automatic test_reset();
        pulse(1, 0, 0, 0, 3'd6);
        pulse(1, 0, 0, 0, 3'd2);
        total++;
        if (cur_len !== 3'd2 || cur_guess !== 12'o6200) begin
            bad++;
            $display("FAIL pre_reset: len=%0d cur=%o, required 2 6200", cur_len, cur_guess);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset_mid_entry");
        pulse(1, 0, 0, 0, 3'd4);
        total++;
        if (cur_len !== 3'd1 || cur_guess !== 12'o4000) begin
            bad++;
            $display("FAIL reset_state_entry: len=%0d cur=%o, required 1 4000", cur_len, cur_guess);
        end
        pulse(0, 1, 0, 0, 0);
        total++;
        if (cur_len !== 3'd0 || cur_guess !== 12'd0) begin
            bad++;
            $display("FAIL back_to_empty: len=%0d cur=%o, required 0 0", cur_len, cur_guess);
        end
        pulse(0, 1, 0, 0, 0);
        total++;
        if (cur_len !== 3'd0) begin
            bad++;
            $display("FAIL back_at_zero: len=%0d, required 0", cur_len);
        end
    endtask

    task automatic test_first_commit();
        commit_guess(12'o5172, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (g1 !== 12'o5172 || guess_count !== 4'd1 || guess_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_commit: g1=%o cnt=%0d valid=%b, required 5172 1 0",
                     g1, guess_count, guess_valid);
        end
    endtask

    task automatic test_backspace();
        pulse(1, 0, 0, 0, 3'd3);
        pulse(1, 0, 0, 0, 3'd4);
        pulse(0, 1, 0, 0, 0);
        total++;
        if (cur_len !== 3'd1 || cur_guess !== 12'o3000) begin
            bad++;
            $display("FAIL back_mid: len=%0d cur=%o, required 1 3000", cur_len, cur_guess);
        end
        pulse(1, 0, 0, 0, 3'd6);
        pulse(1, 0, 0, 0, 3'd0);
        pulse(1, 0, 0, 0, 3'd1);
        sb.push_back('{val: 12'o3601, slot: 1});
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (g2 !== 12'o3601 || guess_count !== 4'd2 || g1 !== 12'o5172) begin
            bad++;
            $display("FAIL backspace_commit: g2=%o cnt=%0d g1=%o, required 3601 2 5172",
                     g2, guess_count, g1);
        end
    endtask

    task automatic test_incomplete();
        pulse(1, 0, 0, 0, 3'd7);
        pulse(1, 0, 0, 0, 3'd7);
        pulse(1, 0, 0, 0, 3'd0);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (cur_len !== 3'd3 || guess_count !== 4'd2 || cur_guess !== 12'o7700) begin
            bad++;
            $display("FAIL submit_incomplete: len=%0d cnt=%0d cur=%o, required 3 2 7700",
                     cur_len, guess_count, cur_guess);
        end
        pulse(1, 0, 0, 0, 3'd2);
        pulse(1, 0, 0, 0, 3'd5);
        total++;
        if (cur_len !== 3'd4 || cur_guess !== 12'o7702) begin
            bad++;
            $display("FAIL enter_in_ready: len=%0d cur=%o, required 4 7702", cur_len, cur_guess);
        end
        pulse(0, 1, 0, 0, 0);
        total++;
        if (cur_len !== 3'd3 || cur_guess !== 12'o7700) begin
            bad++;
            $display("FAIL back_in_ready: len=%0d cur=%o, required 3 7700", cur_len, cur_guess);
        end
        pulse(1, 0, 0, 0, 3'd3);
        sb.push_back('{val: 12'o7703, slot: 2});
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
    endtask

    task automatic test_full();
        for (int s = 3; s < 8; s++) begin
            commit_guess(12'(s * 12'o1111 + 12'o0123), s);
        end
        pulse(0, 0, 0, 0, 0);
        total++;
        if (full !== 1'b1 || guess_count !== 4'd8 || g8 !== 12'(7 * 12'o1111 + 12'o0123)) begin
            bad++;
            $display("FAIL full_reached: full=%b cnt=%0d g8=%o", full, guess_count, g8);
        end
        pulse(1, 0, 0, 0, 3'd1);
        pulse(1, 0, 0, 0, 3'd2);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (cur_len !== 3'd0 || guess_count !== 4'd8 || full !== 1'b1 || g1 !== 12'o5172) begin
            bad++;
            $display("FAIL full_ignores: len=%0d cnt=%0d full=%b g1=%o, required 0 8 1 5172",
                     cur_len, guess_count, full, g1);
        end
        pulse(0, 0, 0, 1, 0);
        check_all_zero("new_game_clear");
    endtask

    task automatic test_priority();
        enter_digits(12'o1234);
        sb.push_back('{val: 12'o1234, slot: 0});
        pulse(0, 1, 1, 0, 0);
        total++;
        if (cur_len !== 3'd4 || cur_guess !== 12'o1234) begin
            bad++;
            $display("FAIL submit_over_back: len=%0d cur=%o, required 4 1234", cur_len, cur_guess);
        end
        pulse(0, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 0);
        total++;
        if (g1 !== 12'o1234 || guess_count !== 4'd1) begin
            bad++;
            $display("FAIL priority_commit: g1=%o cnt=%0d, required 1234 1", g1, guess_count);
        end
        enter_digits(12'o6543);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 1, 0);
        #1;
        check_all_zero("new_game_in_commit");
        pulse(0, 0, 0, 0, 0);
        total++;
        if (guess_valid !== 1'b0 || g2 !== 12'd0) begin
            bad++;
            $display("FAIL discarded_commit: valid=%b g2=%o, required 0 0", guess_valid, g2);
        end
    endtask

    initial begin
        rst = 1'b1;
        new_game = 0; btn_enter = 0; btn_back = 0; btn_submit = 0; digit_in = 0;
        #1;
        check_all_zero("reset_initial");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_first_commit();
        test_backspace();
        test_incomplete();
        test_full();
        test_priority();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected commits never seen, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
